// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg : shared types and constants for the pipeline memory stage
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  typedef enum logic [0:0] {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mstate_t;

  typedef struct packed {
    logic wreg;
    logic m2reg;
    logic wmem;
  } ctl_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

`default_nettype wire

// File: rtl/pipemwreg.sv
// ---------------------------------------------------------------------------
// pipemwreg : MEM/WB pipeline register with load enable and bubble insert
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipemwreg (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] alu,
  input  logic [31:0] mo,
  input  logic [4:0]  rn,
  input  logic        wreg,
  input  logic        m2reg,
  output logic [31:0] walu,
  output logic [31:0] wmo,
  output logic [4:0]  wrn,
  output logic        wwreg,
  output logic        wm2reg
);

  always_ff @(posedge clock) begin
    if (reset) begin
      walu   <= '0;
      wmo    <= '0;
      wrn    <= '0;
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
    end else if (load) begin
      walu   <= alu;
      wmo    <= mo;
      wrn    <= rn;
      wwreg  <= wreg;
      wm2reg <= m2reg;
    end else if (bubble) begin
      // Data fields hold; only the controls that cause side effects are killed.
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipemem_stage.sv
// ---------------------------------------------------------------------------
// pipemem_stage : pipeline memory stage with req/ack data port and stall
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipemem_stage
  import pipe_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mstall,
  output logic [31:0] malu,
  output logic [4:0]  mrn,
  output logic        mwreg,
  output logic        mm2reg,
  output logic [31:0] walu,
  output logic [31:0] wmo,
  output logic [4:0]  wrn,
  output logic        wwreg,
  output logic        wm2reg,
  output logic        bus_err,
  input  logic        err_clr
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] C_MAX_WAIT = CW'(MAX_WAIT);

  logic [31:0] r_mb;
  ctl_t        r_mctl;
  mstate_t     r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;

  logic        w_mem_op;
  logic        w_misaligned;
  logic        w_timeout;
  logic        w_to_err;
  logic [31:0] w_wmo;
  logic        w_wwreg;

  // EXE/MEM register
  always_ff @(posedge clock) begin
    if (reset) begin
      malu   <= '0;
      r_mb   <= '0;
      mrn    <= '0;
      r_mctl <= '0;
    end else if (!mstall) begin
      malu   <= ealu;
      r_mb   <= eb;
      mrn    <= ern;
      r_mctl <= '{wreg: ewreg, m2reg: em2reg, wmem: ewmem};
    end
  end

  assign mwreg  = r_mctl.wreg;
  assign mm2reg = r_mctl.m2reg;

  assign w_mem_op     = r_mctl.m2reg | r_mctl.wmem;
  assign w_misaligned = w_mem_op & (|(malu[1:0] & WORD_ALIGN_MASK));
  assign w_timeout    = (r_state == M_WAIT) && (r_cnt == C_MAX_WAIT);
  // An ack arriving together with the timeout wins: the access succeeded.
  assign w_to_err     = w_timeout & ~dm_ack;

  assign dm_req   = w_mem_op & ~w_misaligned;
  assign dm_we    = dm_req & r_mctl.wmem;
  assign dm_addr  = malu;
  assign dm_wdata = r_mb;
  assign mstall   = dm_req & ~dm_ack & ~w_timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= M_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Counter holds the number of stall cycles already spent on this access.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    if (mstall) begin
      w_cnt_next = r_cnt + CW'(1);
    end
    case (r_state)
      M_IDLE: if (mstall) w_state_next = M_WAIT;
      M_WAIT: if (!mstall) w_state_next = M_IDLE;
      default: w_state_next = M_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else if (w_misaligned | w_to_err) begin
      bus_err <= 1'b1;
    end else if (err_clr) begin
      bus_err <= 1'b0;
    end
  end

  assign w_wmo   = (r_mctl.m2reg & dm_req & dm_ack) ? dm_rdata : 32'h0;
  assign w_wwreg = r_mctl.wreg & ~w_misaligned & ~w_to_err;

  pipemwreg u_mwreg (
    .clock  (clock),
    .reset  (reset),
    .load   (~mstall),
    .bubble (mstall),
    .alu    (malu),
    .mo     (w_wmo),
    .rn     (mrn),
    .wreg   (w_wwreg),
    .m2reg  (r_mctl.m2reg),
    .walu   (walu),
    .wmo    (wmo),
    .wrn    (wrn),
    .wwreg  (wwreg),
    .wm2reg (wm2reg)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipemem_stage.sv
// ---------------------------------------------------------------------------
// tb_pipemem_stage : directed self-checking bench for pipemem_stage
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipemem_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ealu = '0, eb = '0;
  logic [4:0]  ern = '0;
  logic        ewreg = 1'b0, em2reg = 1'b0, ewmem = 1'b0;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = '0;
  logic        mstall;
  logic [31:0] malu;
  logic [4:0]  mrn;
  logic        mwreg, mm2reg;
  logic [31:0] walu, wmo;
  logic [4:0]  wrn;
  logic        wwreg, wm2reg, bus_err;
  logic        err_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  int stall_cycles;

  pipemem_stage #(.MAX_WAIT(15)) dut (
    .clock(clock), .reset(reset), .ealu(ealu), .eb(eb), .ern(ern),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .mstall(mstall),
    .malu(malu), .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
    .walu(walu), .wmo(wmo), .wrn(wrn), .wwreg(wwreg), .wm2reg(wm2reg),
    .bus_err(bus_err), .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_e(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rn,
                       input logic wr, input logic ld, input logic st);
    ealu = a; eb = b; ern = rn; ewreg = wr; em2reg = ld; ewmem = st;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick; tick;
    reset = 1'b0;
    #1;
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_mstall", 32'(mstall), 32'd0);
    chk("rst_walu", walu, 32'd0);
    chk("rst_wwreg", 32'(wwreg), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);

    // Zero-wait load at 0x100, followed back-to-back by a store to 0x104
    set_e(32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick;
    set_e(32'h104, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b1);
    dm_ack = 1'b1; dm_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_req", 32'(dm_req), 32'd1);
    chk("ld_nostall", 32'(mstall), 32'd0);
    chk("ld_addr", dm_addr, 32'h100);
    chk("ld_we", 32'(dm_we), 32'd0);
    tick;
    dm_ack = 1'b0; dm_rdata = 32'h0;
    set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("ld_wmo", wmo, 32'hDEADBEEF);
    chk("ld_wwreg", 32'(wwreg), 32'd1);
    chk("ld_wrn", 32'(wrn), 32'd5);
    chk("st_c1_stall", 32'(mstall), 32'd1);
    chk("st_c1_we", 32'(dm_we), 32'd1);
    chk("st_c1_wdata", dm_wdata, 32'hCAFEF00D);
    tick;
    chk("st_c2_stall", 32'(mstall), 32'd1);
    chk("st_bubble_wwreg", 32'(wwreg), 32'd0);
    chk("st_bubble_wm2reg", 32'(wm2reg), 32'd0);
    chk("st_bubble_walu_hold", walu, 32'h100);
    chk("st_m_hold", malu, 32'h104);
    tick;
    chk("st_c3_stall", 32'(mstall), 32'd1);
    chk("st_c3_wdata", dm_wdata, 32'hCAFEF00D);
    tick;
    dm_ack = 1'b1;
    #1;
    chk("st_c4_nostall", 32'(mstall), 32'd0);
    chk("st_c4_req", 32'(dm_req), 32'd1);
    tick;
    dm_ack = 1'b0;
    #1;
    chk("st_w_walu", walu, 32'h104);
    chk("st_w_wwreg", 32'(wwreg), 32'd0);
    chk("st_w_wmo", wmo, 32'h0);
    chk("st_after_req", 32'(dm_req), 32'd0);

    // Load with no ack: timeout after 15 stall cycles
    set_e(32'h200, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick;
    set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    stall_cycles = 0;
    while (mstall && stall_cycles < 40) begin
      stall_cycles++;
      tick;
    end
    chk("to_stall_cycles", 32'(stall_cycles), 32'd15);
    chk("to_req_held", 32'(dm_req), 32'd1);
    chk("to_err_before", 32'(bus_err), 32'd0);
    tick;
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_wwreg", 32'(wwreg), 32'd0);
    chk("to_walu", walu, 32'h200);
    chk("to_wmo", wmo, 32'h0);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("to_err_cleared", 32'(bus_err), 32'd0);

    // Misaligned load at 0x102; err_clr in the same cycle must lose to the set
    set_e(32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick;
    set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    err_clr = 1'b1;
    #1;
    chk("mis_req", 32'(dm_req), 32'd0);
    chk("mis_stall", 32'(mstall), 32'd0);
    tick;
    chk("mis_bus_err", 32'(bus_err), 32'd1);
    chk("mis_wwreg", 32'(wwreg), 32'd0);
    chk("mis_walu", walu, 32'h102);
    tick;
    err_clr = 1'b0;
    chk("mis_err_cleared", 32'(bus_err), 32'd0);

    // Ack arriving in the timeout cycle counts as a good access
    set_e(32'h300, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0);
    tick;
    set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (15) tick;
    dm_ack = 1'b1; dm_rdata = 32'h12345678;
    #1;
    chk("tack_nostall", 32'(mstall), 32'd0);
    tick;
    dm_ack = 1'b0; dm_rdata = 32'h0;
    chk("tack_wmo", wmo, 32'h12345678);
    chk("tack_wwreg", 32'(wwreg), 32'd1);
    chk("tack_no_err", 32'(bus_err), 32'd0);

    // Reset during the second wait cycle abandons the access
    set_e(32'h400, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick;
    set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick; tick;
    chk("rw_stall_before", 32'(mstall), 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rw_req", 32'(dm_req), 32'd0);
    chk("rw_stall", 32'(mstall), 32'd0);
    chk("rw_malu", malu, 32'h0);
    chk("rw_walu", walu, 32'h0);
    chk("rw_wwreg", 32'(wwreg), 32'd0);
    dm_ack = 1'b1; dm_rdata = 32'h00000BAD;
    tick;
    dm_ack = 1'b0;
    chk("rw_late_wmo", wmo, 32'h0);
    chk("rw_late_wwreg", 32'(wwreg), 32'd0);
    chk("rw_late_err", 32'(bus_err), 32'd0);

    // Plain ALU op flows straight through
    set_e(32'h55, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0);
    tick;
    set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("alu_req", 32'(dm_req), 32'd0);
    chk("alu_mrn", 32'(mrn), 32'd2);
    chk("alu_mwreg", 32'(mwreg), 32'd1);
    tick;
    chk("alu_walu", walu, 32'h55);
    chk("alu_wwreg", 32'(wwreg), 32'd1);
    chk("alu_wrn", 32'(wrn), 32'd2);
    chk("alu_wm2reg", 32'(wm2reg), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
